qreg_shift: RTL
===============

# qreg_shift

Parametrised Q (multiplier/quotient) register for the shift-add datapath. Holds a WIDTH-bit operand, loads it in parallel, then shifts it right one bit per enabled step. Each step takes in a serial bit from the accumulator (A) LSB and presents the current LSB to the add/skip decision. An internal step counter, busy/done handshake and three-state controller sequence exactly WIDTH shifts per operation. This replaces the plain 8-bit Q register and sits between the A register and the multiplier control FSM.

## Interface
- WIDTH, 8, operand width in bits; legal range 2..32
- CW, $clog2(WIDTH+1), step-counter width; derived, not overridden
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset (asserted when 0)
- load  in  1  parallel load strobe; honoured only in IDLE
- load_data  in  WIDTH  value captured on load
- start  in  1  begin a WIDTH-step shift sequence; honoured only in IDLE
- step  in  1  shift enable; honoured only in RUN
- serial_in  in  1  bit shifted into the MSB on each step (A LSB)
- data_out  out  WIDTH  current register contents
- q0  out  1  data_out[0]; multiplier bit for the add/skip decision
- count  out  CW  steps remaining in the current sequence
- busy  out  1  high while in RUN
- done  out  1  one-cycle pulse in DONE

## Operation
- Reset (reset=0, asynchronous) forces state=IDLE, data_out=0, count=0, busy=0, done=0. These values hold until the first rising clk edge with reset=1.
- States:
  - IDLE → RUN on start=1 (and load=0). Sets count=WIDTH.
  - RUN → DONE on the step edge that takes count from 1 to 0.
  - DONE → IDLE unconditionally after one cycle.
- IDLE:
  - load=1 → data_out <= load_data.
  - load and start in the same cycle: load wins, start is dropped, state stays IDLE.
  - step is ignored.
- RUN, step=1:
  - data_out <= {serial_in, data_out[WIDTH-1:1]}
  - count <= count-1
- RUN, step=0: data_out, count and state hold, with no cycle limit.
- RUN: load and start are ignored; data_out is not disturbed.
- DONE:
  - done=1 and busy=0.
  - data_out holds the final shifted value and count=0.
  - load, start and step are ignored.
- busy is a registered decode of the RUN state. done is a registered decode of the DONE state. Neither has a combinational path from any input.
- q0 is combinational from data_out[0] only.
- Count has no wrap-around: it never decrements below 0 and never exceeds WIDTH.

## Timing
- Load latency: 1 cycle. load at edge k makes data_out valid after edge k.
- start accepted at edge k: busy=1 and count=WIDTH after edge k.
- Each step=1 edge in RUN shifts exactly one bit. The new q0 is visible in the same cycle after the edge.
- The final (WIDTH-th) step edge:
  - busy drops to 0, done rises to 1, count becomes 0.
  - On the next edge done returns to 0 and state returns to IDLE.
- Minimum operation: 1 start cycle + WIDTH step cycles + 1 DONE cycle. A new start is accepted earliest on the cycle after DONE.
- Reset asserted mid-RUN or mid-DONE aborts the sequence immediately, with all outputs at reset values. No done pulse is produced for the aborted sequence.
- Reset deassertion is synchronous to clk at the system level. The block needs no internal synchroniser.

## Test plan
- Reset mid-operation: load 0xFF, start, 3 steps, assert reset=0 asynchronously between edges → immediately data_out=0x00, count=0, busy=0, done=0. After release, state is IDLE and a fresh load 0x12 captures 0x12.
- Load and shift out, WIDTH=8: load 0xB5, start, 8 consecutive steps with serial_in=0 →
  - q0 sequence 1,0,1,0,1,1,0,1
  - count sequence 8→7…→0
  - final data_out=0x00
  - done high for exactly one cycle after the 8th step, busy low from that edge.
- Serial fill: load 0x00, start, 8 steps with serial_in=1 → data_out=0x80,0xC0,…,0xFF after steps 1..8.
- Stalled steps: load 0x0F, start, step pattern 1,0,0,1,0,1,1,1,1,1,1 → data_out and count hold on every step=0 cycle. done fires only after the 8th step=1 edge.
- Ignored controls:
  - load 0x3C during RUN → data_out unchanged.
  - start during RUN or DONE → count not reloaded.
  - load and start together in IDLE with load_data=0x5A → data_out=0x5A, busy stays 0.
- Parameter sweep: WIDTH=4 and WIDTH=16 with a known load value and serial pattern → exactly WIDTH steps to done, and CW sized so that count starts at WIDTH.

Source files
------------

// File: rtl/qreg_shift.sv
// qreg_shift: Q (multiplier/quotient) register for the shift-add datapath.
// Latency: parallel load visible 1 cycle after the load edge. Each enabled step shifts one bit in 1 cycle.
// Backpressure: step=0 in RUN stalls the sequence indefinitely. Load and start are honoured only in IDLE.
//
// Ports:
//   clk, reset (async, active-low)
//   load / load_data     parallel load, IDLE only
//   start                begin a WIDTH-step sequence, IDLE only
//   step / serial_in     shift enable and MSB fill bit (A register LSB), RUN only
//   data_out, q0         register contents and its LSB (add/skip decision)
//   count                steps remaining in the current sequence
//   busy, done           registered decodes of RUN and DONE
module qreg_shift #(
   parameter  int WIDTH = 8,
   localparam int CW    = $clog2(WIDTH + 1)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             load,
   input  logic [WIDTH-1:0] load_data,
   input  logic             start,
   input  logic             step,
   input  logic             serial_in,
   output logic [WIDTH-1:0] data_out,
   output logic             q0,
   output logic [CW-1:0]    count,
   output logic             busy,
   output logic             done
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] data_q, data_d;
   logic [CW-1:0]    count_q, count_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;

   always_comb begin
      state_d = state_q;
      data_d  = data_q;
      count_d = count_q;
      case (state_q)
         ST_IDLE: begin
            // Load has priority: a simultaneous start is dropped.
            if (load) begin
               data_d = load_data;
            end else if (start) begin
               state_d = ST_RUN;
               count_d = CW'(WIDTH);
            end
         end
         ST_RUN: begin
            if (step) begin
               data_d = {serial_in, data_q[WIDTH-1:1]};
               // Guarded so the counter can never wrap below zero.
               if (count_q != '0) begin
                  count_d = count_q - CW'(1);
               end
               if (count_q <= CW'(1)) begin
                  state_d = ST_DONE;
               end
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
      // Status flags are decoded from the next state so they are registered
      // and line up with the state they describe.
      busy_d = (state_d == ST_RUN);
      done_d = (state_d == ST_DONE);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= ST_IDLE;
         data_q  <= '0;
         count_q <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         data_q  <= data_d;
         count_q <= count_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   assign data_out = data_q;
   assign q0       = data_q[0];
   assign count    = count_q;
   assign busy     = busy_q;
   assign done     = done_q;

endmodule
